// File: rtl/aexm_icache.sv
// rtl/aexm_icache.sv - direct-mapped read-only instruction cache in front of aexm_ibuf
//
// Purpose:
//   Registered lookup; a hit shows its instruction one cycle after ic_en.
//   A miss raises ic_stall and refills the whole line, words 0..last, from
//   the memory port. After the refill a DONE cycle re-reads the arrays so
//   the following IDLE cycle hits.
//
// Ports:
//   gclk, grst          clock, synchronous active-high reset
//   ic_en, iadr         lookup request and fetch byte address
//   aexm_icache_datai   instruction word to the ibuf
//   ic_stall            1 = aexm_icache_datai not valid
//   mem_req, mem_adr    refill word request and word-aligned address
//   mem_ack, mem_dat    refill handshake and data
//   ic_inval            (ICACHE_INVAL_EN only) invalidate-all pulse
//
// Configuration: define ICACHE_INVAL_EN to add ic_inval and the INVAL sweep.
module aexm_icache #(
  parameter int IDX_W  = 8,
  parameter int LINE_W = 2,
  parameter int ADR_W  = 32
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             ic_en,
  input  logic [ADR_W-1:0] iadr,
  output logic [31:0]      aexm_icache_datai,
  output logic             ic_stall,
  output logic             mem_req,
  output logic [ADR_W-1:0] mem_adr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_dat
`ifdef ICACHE_INVAL_EN
  ,
  input  logic             ic_inval
`endif
);

  localparam int TAG_W = ADR_W - 2 - LINE_W - IDX_W;
  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = 1 << LINE_W;
  localparam int TAG_LO = LINE_W + IDX_W + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
`ifdef ICACHE_INVAL_EN
  localparam logic [1:0] INVAL = 2'd3;
`endif

  logic [31:0]      rDatArr [0:LINES*WORDS-1];
  logic [TAG_W-1:0] rTagArr [0:LINES-1];
  logic [LINES-1:0] rValid;

  logic [1:0]       rState;
  logic [LINE_W-1:0] rCnt;
  logic [ADR_W-1:0] rADR;
  logic             rLook;    // a lookup has been issued since reset
  logic             rHitV;    // registered valid bit of the looked-up line
  logic [TAG_W-1:0] rTag;     // registered tag of the looked-up line
`ifdef ICACHE_INVAL_EN
  logic [IDX_W-1:0] rInvCnt;
  logic             rInvPend;
`endif

  logic [ADR_W-1:0] rdAdr;
  logic [IDX_W-1:0] rdIdx;
  logic [LINE_W-1:0] rdOff;
  logic [IDX_W-1:0] rIdx;
  logic             hit;
  logic             miss;
  logic             lookEn;
  logic             doRead;
  logic             unusedBits;

  // DONE re-reads the line being refilled; otherwise the read port follows iadr.
  assign rdAdr = (rState == DONE) ? rADR : iadr;
  assign rdIdx = rdAdr[LINE_W+IDX_W+1:LINE_W+2];
  assign rdOff = rdAdr[LINE_W+1:2];
  assign rIdx  = rADR[LINE_W+IDX_W+1:LINE_W+2];
  assign unusedBits = ^{rdAdr[1:0], rdAdr[ADR_W-1:TAG_LO]};

  assign hit  = rHitV && (rTag == rADR[ADR_W-1:TAG_LO]);
  // Before the first lookup there is nothing to miss on.
  assign miss = rLook && !hit;

  assign ic_stall = (rState != IDLE) || miss;
  assign lookEn   = ic_en && !ic_stall;
  assign doRead   = lookEn || (rState == DONE);

  assign mem_req = (rState == FILL);
  assign mem_adr = (rState == FILL) ? {rADR[ADR_W-1:LINE_W+2], rCnt, 2'b00} : '0;

  // Data and tag arrays carry no reset; only the valid bits gate their use.
  always_ff @(posedge gclk) begin
    if (!grst && rState == FILL && mem_ack) begin
      rDatArr[{rIdx, rCnt}] <= mem_dat;
      if (rCnt == '1)
        rTagArr[rIdx] <= rADR[ADR_W-1:TAG_LO];
    end
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      rState            <= IDLE;
      rCnt              <= '0;
      rADR              <= '0;
      rLook             <= 1'b0;
      rHitV             <= 1'b0;
      rTag              <= '0;
      rValid            <= '0;
      aexm_icache_datai <= 32'h80000000;
`ifdef ICACHE_INVAL_EN
      rInvCnt           <= '0;
      rInvPend          <= 1'b0;
`endif
    end else begin
      if (doRead) begin
        rHitV             <= rValid[rdIdx];
        rTag              <= rTagArr[rdIdx];
        aexm_icache_datai <= rDatArr[{rdIdx, rdOff}];
      end
      if (lookEn) begin
        rADR  <= iadr;
        rLook <= 1'b1;
      end
`ifdef ICACHE_INVAL_EN
      // An invalidate arriving mid-refill waits until the line is complete.
      if (ic_inval && (rState == FILL || rState == DONE))
        rInvPend <= 1'b1;
`endif
      case (rState)
        IDLE: begin
`ifdef ICACHE_INVAL_EN
          if (ic_inval || rInvPend) begin
            rState   <= INVAL;
            rInvCnt  <= '0;
            rInvPend <= 1'b0;
          end else
`endif
          if (miss) begin
            rState <= FILL;
            rCnt   <= '0;
          end
        end
        FILL: begin
          if (mem_ack) begin
            rCnt <= rCnt + 1'b1;
            // Valid is only set with the last word, so an interrupted
            // refill never leaves a usable line behind.
            if (rCnt == '1) begin
              rValid[rIdx] <= 1'b1;
              rState       <= DONE;
            end
          end
        end
        DONE: rState <= IDLE;
`ifdef ICACHE_INVAL_EN
        INVAL: begin
          rValid[rInvCnt] <= 1'b0;
          rInvCnt         <= rInvCnt + 1'b1;
          // Finish through DONE so rADR is looked up again.
          if (rInvCnt == '1)
            rState <= DONE;
        end
`endif
        default: rState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aexm_icache.sv
// tb/tb_aexm_icache.sv - directed self-checking bench for aexm_icache
module tb_aexm_icache;

  logic        gclk = 1'b0;
  logic        grst;
  logic        ic_en;
  logic [31:0] iadr;
  logic [31:0] aexm_icache_datai;
  logic        ic_stall;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_ack;
  logic [31:0] mem_dat;
`ifdef ICACHE_INVAL_EN
  logic        ic_inval;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] memBase;
  int          ackDelay;
  int          waitCnt = 0;
  logic [31:0] ackAdr [0:63];
  int          ackN = 0;
  int          adrMoves = 0;
  int          n;
  int          base;

  always #5 gclk = ~gclk;

  aexm_icache dut (
    .gclk(gclk),
    .grst(grst),
    .ic_en(ic_en),
    .iadr(iadr),
    .aexm_icache_datai(aexm_icache_datai),
    .ic_stall(ic_stall),
    .mem_req(mem_req),
    .mem_adr(mem_adr),
    .mem_ack(mem_ack),
    .mem_dat(mem_dat)
`ifdef ICACHE_INVAL_EN
    ,
    .ic_inval(ic_inval)
`endif
  );

  // Memory model: ack after ackDelay wait cycles, data = base + word offset + 1.
  assign mem_ack = mem_req && (waitCnt == ackDelay);
  assign mem_dat = memBase + {28'd0, mem_adr[3:2]} + 32'd1;

  always @(posedge gclk) begin
    if (mem_req && !mem_ack) waitCnt <= waitCnt + 1;
    else                     waitCnt <= 0;
    if (mem_ack && ackN < 64) begin
      ackAdr[ackN] <= mem_adr;
      ackN <= ackN + 1;
    end
  end

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts consecutive stalled cycles starting with the current one, and
  // notes any mem_adr change while a request is waiting for its ack.
  task automatic waitStall(input int bound, output int cnt);
    logic        pReq;
    logic        pAck;
    logic [31:0] pAdr;
    cnt = 0;
    while (ic_stall && cnt < bound) begin
      pReq = mem_req;
      pAck = mem_ack;
      pAdr = mem_adr;
      cnt++;
      step();
      if (pReq && !pAck && mem_req && mem_adr !== pAdr) adrMoves++;
    end
  endtask

  initial begin
    grst = 1'b1; ic_en = 1'b0; iadr = 32'h0;
    memBase = 32'h0; ackDelay = 0;
`ifdef ICACHE_INVAL_EN
    ic_inval = 1'b0;
`endif
    step();
    step();
    check("rst_datai", aexm_icache_datai, 32'h80000000);
    check("rst_stall", {31'd0, ic_stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_adr", mem_adr, 32'h0);

    // Cold miss at 0x100, zero-wait refill.
    grst = 1'b0;
    memBase = 32'hA0000000;
    ic_en = 1'b1; iadr = 32'h100;
    base = ackN;
    step();
    check("t1_miss_stall", {31'd0, ic_stall}, 32'd1);
    waitStall(100, n);
    check("t1_stall_cycles", n, 32'd6);
    check("t1_acks", ackN - base, 32'd4);
    check("t1_adr0", ackAdr[base], 32'h100);
    check("t1_adr1", ackAdr[base+1], 32'h104);
    check("t1_adr2", ackAdr[base+2], 32'h108);
    check("t1_adr3", ackAdr[base+3], 32'h10C);
    check("t1_datai", aexm_icache_datai, 32'hA0000001);

    // Back-to-back hits within the line.
    for (int i = 1; i < 4; i++) begin
      iadr = 32'h100 + 32'(4 * i);
      step();
      check("t2_stall", {31'd0, ic_stall}, 32'd0);
      check("t2_req", {31'd0, mem_req}, 32'd0);
      check("t2_datai", aexm_icache_datai, 32'hA0000001 + 32'(i));
    end

    // ic_en low: output holds.
    ic_en = 1'b0; iadr = 32'h200;
    step();
    step();
    check("hold_datai", aexm_icache_datai, 32'hA0000004);
    check("hold_stall", {31'd0, ic_stall}, 32'd0);

    // Conflict on the same index, then the evicted line misses again.
    memBase = 32'hB0000000;
    ic_en = 1'b1; iadr = 32'h1100;
    base = ackN;
    step();
    check("t3_miss_stall", {31'd0, ic_stall}, 32'd1);
    waitStall(100, n);
    check("t3_stall_cycles", n, 32'd6);
    check("t3_adr0", ackAdr[base], 32'h1100);
    check("t3_adr3", ackAdr[base+3], 32'h110C);
    check("t3_datai", aexm_icache_datai, 32'hB0000001);
    memBase = 32'hA0000000;
    iadr = 32'h100;
    step();
    check("t3_evict_miss", {31'd0, ic_stall}, 32'd1);
    waitStall(100, n);
    check("t3_refill_cycles", n, 32'd6);
    check("t3_refill_datai", aexm_icache_datai, 32'hA0000001);

    // Slow memory: three wait cycles per word.
    memBase = 32'hC0000000;
    ackDelay = 3;
    adrMoves = 0;
    iadr = 32'h300;
    base = ackN;
    step();
    waitStall(200, n);
    check("t4_stall_cycles", n, 32'd18);
    check("t4_adr_stable", adrMoves, 32'd0);
    check("t4_acks", ackN - base, 32'd4);
    check("t4_adr1", ackAdr[base+1], 32'h304);
    check("t4_datai", aexm_icache_datai, 32'hC0000001);

    // Reset after two words of a refill.
    memBase = 32'hD0000000;
    ackDelay = 0;
    iadr = 32'h400;
    step();   // IDLE, miss
    step();   // FILL word 0
    step();   // FILL word 1
    step();   // FILL word 2
    check("t5_req_before", {31'd0, mem_req}, 32'd1);
    grst = 1'b1;
    step();
    check("t5_req_after", {31'd0, mem_req}, 32'd0);
    check("t5_stall_after", {31'd0, ic_stall}, 32'd0);
    check("t5_datai_after", aexm_icache_datai, 32'h80000000);
    grst = 1'b0;
    base = ackN;
    step();
    check("t5_refetch_miss", {31'd0, ic_stall}, 32'd1);
    waitStall(100, n);
    check("t5_stall_cycles", n, 32'd6);
    check("t5_acks", ackN - base, 32'd4);
    check("t5_adr0", ackAdr[base], 32'h400);
    check("t5_datai", aexm_icache_datai, 32'hD0000001);

`ifdef ICACHE_INVAL_EN
    // Invalidate sweep, then the re-lookup of 0x400 misses and refills.
    base = ackN;
    ic_inval = 1'b1;
    step();
    ic_inval = 1'b0;
    check("t6_inval_stall", {31'd0, ic_stall}, 32'd1);
    waitStall(1000, n);
    check("t6_stall_cycles", n, 32'd263);
    check("t6_acks", ackN - base, 32'd4);
    check("t6_datai", aexm_icache_datai, 32'hD0000001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
